// File: rtl/emotion_argmax.sv
// -----------------------------------------------------------------------------
// emotion_argmax
//   Serial argmax over the packed class scores of the Mini-Xception classifier.
//   A frame is captured in one beat, then one class is compared per cycle.
//   The block reports the winning class, its score and a low-confidence flag
//   (top-two margin below MARGIN). It also keeps an accepted-frame counter and
//   a sticky flag for beats that arrive while a scan is in progress.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   Data_In    in   NUM_CLASS signed scores, score k at [k*DATA_WIDHT +: DATA_WIDHT]
//   Valid_In   in   single-cycle qualifier for Data_In
//   Busy       out  high while a frame is being scanned
//   Class_Out  out  index of the maximum score
//   Max_Out    out  maximum score value
//   Low_Conf   out  (best - second) < MARGIN
//   Valid_Out  out  one-cycle pulse qualifying Class_Out / Max_Out / Low_Conf
//   Frame_Cnt  out  accepted frames, wraps
//   Drop_Flag  out  sticky, set when a beat is ignored because Busy was high
// -----------------------------------------------------------------------------
module emotion_argmax #(
    parameter int unsigned DATA_WIDHT = 32,
    parameter int unsigned NUM_CLASS  = 7,
    parameter int unsigned MARGIN     = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDHT*NUM_CLASS-1:0]  Data_In,
    input  logic                             Valid_In,
    output logic                             Busy,
    output logic [2:0]                       Class_Out,
    output logic [DATA_WIDHT-1:0]            Max_Out,
    output logic                             Low_Conf,
    output logic                             Valid_Out,
    output logic [CNT_WIDTH-1:0]             Frame_Cnt,
    output logic                             Drop_Flag
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIFF_W = DATA_WIDHT + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
    localparam logic signed [DATA_WIDHT-1:0] MOST_NEG = {1'b1, {(DATA_WIDHT-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    state_e                          state_q;
    logic [DATA_WIDHT*NUM_CLASS-1:0] data_q;
    logic [IDX_W-1:0]                idx_q;
    logic signed [DATA_WIDHT-1:0]    best_q;
    logic signed [DATA_WIDHT-1:0]    second_q;
    logic [IDX_W-1:0]                best_idx_q;
    logic [2:0]                      class_q;
    logic [DATA_WIDHT-1:0]           max_q;
    logic                            low_conf_q;
    logic                            valid_q;
    logic [CNT_WIDTH-1:0]            frame_cnt_q;
    logic                            drop_q;

    logic signed [DATA_WIDHT-1:0]    score_a [NUM_CLASS];
    logic signed [DATA_WIDHT-1:0]    cur_score;
    logic signed [DATA_WIDHT-1:0]    best_d;
    logic signed [DATA_WIDHT-1:0]    second_d;
    logic [IDX_W-1:0]                best_idx_d;
    logic [DIFF_W-1:0]               diff;
    logic                            low_conf_d;

    // Unpack the captured beat into per-class scores.
    always_comb begin
        for (int k = 0; k < int'(NUM_CLASS); k++) begin
            score_a[k] = data_q[k*DATA_WIDHT +: DATA_WIDHT];
        end
    end

    assign cur_score = score_a[idx_q];

    // One compare step; strict '>' keeps the lower index on ties while an
    // equal score still lands in second, giving a zero margin.
    always_comb begin
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        if (cur_score > best_q) begin
            second_d   = best_q;
            best_d     = cur_score;
            best_idx_d = idx_q;
        end else if (cur_score > second_q) begin
            second_d   = cur_score;
        end
    end

    // Margin in one extra bit so a full-range difference cannot wrap;
    // best >= second always, so the result is non-negative.
    always_comb begin
        diff       = {best_d[DATA_WIDHT-1], best_d} - {second_d[DATA_WIDHT-1], second_d};
        low_conf_d = (diff < DIFF_W'(MARGIN));
    end

    // Capture / scan state machine with registered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            second_q    <= '0;
            best_idx_q  <= '0;
            class_q     <= '0;
            max_q       <= '0;
            low_conf_q  <= 1'b0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Valid_In) begin
                        data_q      <= Data_In;
                        best_q      <= Data_In[DATA_WIDHT-1:0];
                        second_q    <= MOST_NEG;
                        best_idx_q  <= '0;
                        idx_q       <= IDX_W'(1);
                        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
                        state_q     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // No back-pressure: a beat during a scan is lost.
                    if (Valid_In) begin
                        drop_q <= 1'b1;
                    end
                    best_q     <= best_d;
                    second_q   <= second_d;
                    best_idx_q <= best_idx_d;
                    if (idx_q == LAST_IDX) begin
                        class_q    <= 3'(best_idx_d);
                        max_q      <= best_d;
                        low_conf_q <= low_conf_d;
                        valid_q    <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    assign Busy      = (state_q == S_SCAN);
    assign Class_Out = class_q;
    assign Max_Out   = max_q;
    assign Low_Conf  = low_conf_q;
    assign Valid_Out = valid_q;
    assign Frame_Cnt = frame_cnt_q;
    assign Drop_Flag = drop_q;

endmodule
